// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg
//   Shared types and the round-robin pick function for the sp_ram arbiter.
//   The index type is sized for the largest supported master count (8),
//   so every instance uses the same 3-bit master index regardless of
//   NUM_MASTERS; the unused upper values are never produced.
package sp_ram_arb_pkg;

  localparam int MAX_MASTERS = 8;
  // Index width for MAX_MASTERS, never below 1.
  localparam int IDX_W = (MAX_MASTERS > 1) ? $clog2(MAX_MASTERS) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  // Winner = first requester found scanning upward from ptr, wrapping at num.
  // idx is 0 when nothing requests, so the datapath defaults to master 0.
  function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                    input idx_t ptr,
                                    input int num);
    pick_t res;
    int    k;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (i < num) begin
        // ptr < num, so one subtraction is enough to wrap.
        k = int'(ptr) + i;
        if (k >= num) k = k - num;
        if (!res.valid && req[k[IDX_W-1:0]]) begin
          res.valid = 1'b1;
          res.idx   = k[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if
//   Bundles the per-master request/response bus and the single sp_ram
//   slave port. Signal names keep the arbiter's point of view (_i = into
//   the arbiter, _o = out of it).
//   modport slave  : the arbiter itself.
//   modport master : the surrounding system (bus masters plus sp_ram).
interface sp_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Master side, master k occupies slice k of each packed vector.
  logic [NUM_MASTERS-1:0]            m_req_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i;
  logic [NUM_MASTERS-1:0]            m_gnt_o;
  logic [NUM_MASTERS-1:0]            m_rvalid_o;
  logic [DATA_WIDTH-1:0]             m_rdata_o;

  // sp_ram side.
  logic                  s_req_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic                  s_we_o;
  logic [DATA_WIDTH-1:0] s_wdata_o;
  logic [BE_WIDTH-1:0]   s_be_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [DATA_WIDTH-1:0] s_rdata_i;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_wdata_o, s_be_o,
    input  s_gnt_i, s_rvalid_i, s_rdata_i
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_wdata_i, m_be_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_wdata_o, s_be_o,
    output s_gnt_i, s_rvalid_i, s_rdata_i
  );

endinterface

// File: rtl/sp_ram_arb_id_fifo.sv
// sp_ram_arb_id_fifo
//   Small FIFO of master indices, one entry per granted-but-unanswered
//   transaction. The head is read combinationally (show-ahead) because the
//   response must be routed in the same cycle rvalid arrives.
//   Ports: clk, rst_n (async active-low), push/push_data, pop,
//          full, empty, head.
//   push is ignored when full and pop when empty.
module sp_ram_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally; a depth of
  // one keeps both pointers pinned at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (DEPTH == 1) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (DEPTH == 1) ? '0 : rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
//   Shares one sp_ram slave port between NUM_MASTERS requesters. The
//   request phase is a purely combinational round-robin mux (no added
//   latency); an ID FIFO remembers who was granted so each rvalid/rdata is
//   steered back to its issuer, in order.
//   Ports: clk, rst_n (async active-low), bus (sp_ram_arbiter_if.slave:
//          per-master req/addr/we/wdata/be in, gnt/rvalid/rdata out, and
//          the sp_ram req/addr/we/wdata/be out, gnt/rvalid/rdata in),
//          err_o (sticky: rvalid seen with nothing outstanding).
//   All outputs are held at 0 while rst_n is low.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_OUTST   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sp_ram_arbiter_if.slave  bus,
  output logic             err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [MAX_MASTERS-1:0] req_pad;
  pick_t                  pick;
  idx_t                   rr_ptr_reg;
  idx_t                   rr_ptr_next;
  logic                   err_reg;
  logic                   fifo_full;
  logic                   fifo_empty;
  idx_t                   fifo_head;
  logic                   s_req;
  logic                   handshake;
  logic                   rsp_pop;
  logic [NUM_MASTERS-1:0] gnt_vec;
  logic [NUM_MASTERS-1:0] rvalid_vec;

  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_MASTERS-1:0] = bus.m_req_i;
  end

  assign pick = rr_pick(req_pad, rr_ptr_reg, NUM_MASTERS);

  // A full ID FIFO blocks the request phase even if a pop lands in the
  // same cycle; requests resume the cycle after.
  assign s_req     = rst_n & pick.valid & ~fifo_full;
  assign handshake = s_req & bus.s_gnt_i;
  assign rsp_pop   = rst_n & bus.s_rvalid_i & ~fifo_empty;

  assign rr_ptr_next = (pick.idx == idx_t'(NUM_MASTERS - 1)) ? '0
                                                             : idx_t'(pick.idx + 1'b1);

  // Request path: winner's fields (master 0's when idle), zero in reset.
  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = rst_n ? bus.m_addr_i[pick.idx*ADDR_WIDTH +: ADDR_WIDTH]  : '0;
  assign bus.s_we_o    = rst_n & bus.m_we_i[pick.idx];
  assign bus.s_wdata_o = rst_n ? bus.m_wdata_i[pick.idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.s_be_o    = rst_n ? bus.m_be_i[pick.idx*BE_WIDTH +: BE_WIDTH]       : '0;

  // Grant and response demux.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_demux
    assign gnt_vec[gi]    = handshake & (pick.idx == idx_t'(gi));
    assign rvalid_vec[gi] = rsp_pop & (fifo_head == idx_t'(gi));
  end

  assign bus.m_gnt_o    = gnt_vec;
  assign bus.m_rvalid_o = rvalid_vec;
  assign bus.m_rdata_o  = rst_n ? bus.s_rdata_i : '0;
  assign err_o          = err_reg;

  // Pointer only advances on a handshake, so a stalled winner keeps its
  // priority until the slave finally grants it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (handshake) rr_ptr_reg <= rr_ptr_next;
      if (bus.s_rvalid_i && fifo_empty) err_reg <= 1'b1;
    end
  end

  sp_ram_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (handshake),
    .push_data (pick.idx),
    .pop       (rsp_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter
//   Directed bench for sp_ram_arbiter (2 masters, 2 outstanding) against a
//   behavioural sp_ram with a configurable response latency. Stimulus
//   pushes the expected grants/responses (tagged with the cycle they must
//   appear in) into queues; a monitor pops and compares them whenever the
//   DUT asserts a grant or a response.
module tb_sp_ram_arbiter;

  localparam int NM = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MO = 2;

  typedef struct {
    int          cyc;
    logic [1:0]  v;
    logic [31:0] d;
    bit          chk;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int lat        = 1;
  int inject_cyc = -1;

  logic [31:0] ram [256];
  exp_t  gq[$];
  exp_t  rq[$];
  pend_t pend[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_OUTST   (MO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%08h expected=0x%08h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=0x%08h", name, cyc, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input bit req, input bit we,
                       input logic [7:0] a, input logic [31:0] wd);
    bus.m_req_i[k]            = req;
    bus.m_we_i[k]             = we;
    bus.m_addr_i[k*AW +: AW]  = a;
    bus.m_wdata_i[k*DW +: DW] = wd;
    bus.m_be_i[k*4 +: 4]      = 4'hF;
  endtask

  task automatic exp_g(input int c, input logic [1:0] v);
    exp_t e;
    e.cyc = c; e.v = v; e.d = '0; e.chk = 1'b0;
    gq.push_back(e);
  endtask

  task automatic exp_r(input int c, input logic [1:0] v, input logic [31:0] d, input bit chk);
    exp_t e;
    e.cyc = c; e.v = v; e.d = d; e.chk = chk;
    rq.push_back(e);
  endtask

  // sp_ram model, request side: act on each handshake seen mid-cycle.
  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      if (rst_n && bus.s_req_o && bus.s_gnt_i) begin
        p.due = cyc + lat;
        if (bus.s_we_o) begin
          for (int b = 0; b < 4; b++)
            if (bus.s_be_o[b]) ram[bus.s_addr_o][8*b +: 8] = bus.s_wdata_o[8*b +: 8];
          p.d = '0;
        end else begin
          p.d = ram[bus.s_addr_o];
        end
        pend.push_back(p);
      end
    end
  end

  // sp_ram model, response side (plus one-shot spurious rvalid injection).
  initial begin
    bus.s_gnt_i    = 1'b1;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i  = '0;
    forever begin
      tick();
      if (cyc == inject_cyc) begin
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'hDEAD_0000;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = pend[0].d;
        void'(pend.pop_front());
      end else begin
        bus.s_rvalid_i = 1'b0;
        bus.s_rdata_i  = '0;
      end
    end
  end

  // Monitor: compare every grant and every response against the queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.m_gnt_o !== 2'b00) begin
        if (gq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_gnt cyc=%0d actual=%b expected=none", cyc, bus.m_gnt_o);
        end else begin
          e = gq.pop_front();
          check("gnt_cycle", 32'(cyc), 32'(e.cyc));
          check("gnt_vec", 32'(bus.m_gnt_o), 32'(e.v));
        end
      end
      if (bus.m_rvalid_o !== 2'b00) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rvalid cyc=%0d actual=%b expected=none", cyc, bus.m_rvalid_o);
        end else begin
          e = rq.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
          check("rsp_vec", 32'(bus.m_rvalid_o), 32'(e.v));
          if (e.chk) check("rsp_data", bus.m_rdata_o, e.d);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int         base;
    logic [7:0] sreq_pat;

    for (int a = 0; a < 256; a++) ram[a] = 32'hA5A5_0000 | 32'(a);
    bus.m_req_i   = '0;
    bus.m_addr_i  = '0;
    bus.m_we_i    = '0;
    bus.m_wdata_i = '0;
    bus.m_be_i    = '1;

    // Reset held with both masters requesting: everything must stay 0.
    rst_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 8'h80, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h40, 32'h0);
    repeat (2) tick();
    sample();
    check("rst_s_req",  32'(bus.s_req_o),  32'h0);
    check("rst_gnt",    32'(bus.m_gnt_o),  32'h0);
    check("rst_s_addr", 32'(bus.s_addr_o), 32'h0);
    check("rst_err",    32'(err),          32'h0);
    tick();
    rst_n = 1'b1;
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);

    // 1: both request 0x80 -> alternating grants, responses one cycle later.
    tick();
    base = cyc;
    set_m(0, 1'b1, 1'b0, 8'h80, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h80, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      exp_g(base + i, (i % 2 == 1) ? 2'b10 : 2'b01);
      exp_r(base + i + 1, (i % 2 == 1) ? 2'b10 : 2'b01, 32'hA5A5_0080, 1'b1);
    end
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) tick();

    // 2: m0 writes 0xBEEF to 0xCC, then m1 reads it back.
    tick();
    base = cyc;
    set_m(0, 1'b1, 1'b1, 8'hCC, 32'h0000_BEEF);
    exp_g(base, 2'b01);
    exp_r(base + 1, 2'b01, 32'h0, 1'b0);
    sample();
    check("t2_s_we",    32'(bus.s_we_o),  32'h1);
    check("t2_s_addr",  32'(bus.s_addr_o), 32'hCC);
    check("t2_s_wdata", bus.s_wdata_o,    32'h0000_BEEF);
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'hCC, 32'h0);
    exp_g(base + 1, 2'b10);
    exp_r(base + 2, 2'b10, 32'h0000_BEEF, 1'b1);
    tick();
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) tick();

    // 6: only m1 for 4 cycles, then both -> m0 wins, then m1.
    tick();
    base = cyc;
    set_m(1, 1'b1, 1'b0, 8'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      exp_g(base + i, 2'b10);
      exp_r(base + i + 1, 2'b10, 32'hA5A5_0040, 1'b1);
    end
    tick();
    set_m(0, 1'b1, 1'b0, 8'h80, 32'h0);
    exp_g(base + 4, 2'b01);
    exp_r(base + 5, 2'b01, 32'hA5A5_0080, 1'b1);
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    exp_g(base + 5, 2'b10);
    exp_r(base + 6, 2'b10, 32'hA5A5_0040, 1'b1);
    tick();
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) tick();

    // 3: slave answers after 3 cycles; FIFO fills and blocks s_req_o.
    tick();
    lat = 3;
    tick();
    base = cyc;
    set_m(0, 1'b1, 1'b0, 8'h10, 32'h0);
    sreq_pat = 8'b0011_0011;
    exp_r(base + 3, 2'b01, 32'hA5A5_0010, 1'b1);
    exp_r(base + 4, 2'b01, 32'hA5A5_0010, 1'b1);
    exp_r(base + 7, 2'b01, 32'hA5A5_0010, 1'b1);
    exp_r(base + 8, 2'b01, 32'hA5A5_0010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (sreq_pat[i]) exp_g(base + i, 2'b01);
      sample();
      check("t3_s_req", 32'(bus.s_req_o), 32'(sreq_pat[i]));
    end
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) tick();
    lat = 1;

    // 4: spurious rvalid with nothing outstanding.
    tick();
    base = cyc;
    inject_cyc = base + 1;
    tick();
    sample();
    check("t4_m_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    check("t4_err_pre",  32'(err),            32'h0);
    tick();
    sample();
    check("t4_err_set",  32'(err),            32'h1);
    repeat (3) tick();
    sample();
    check("t4_err_sticky", 32'(err),          32'h1);

    // 5: reset with two reads outstanding; first grant after reset is m0.
    tick();
    lat = 3;
    base = cyc;
    set_m(0, 1'b1, 1'b0, 8'h10, 32'h0);
    exp_g(base, 2'b01);
    tick();
    exp_g(base + 1, 2'b01);
    tick();
    rst_n = 1'b0;
    pend.delete();
    set_m(0, 1'b1, 1'b0, 8'h80, 32'h0);
    set_m(1, 1'b1, 1'b0, 8'h40, 32'h0);
    sample();
    check("t5_rst_s_req", 32'(bus.s_req_o), 32'h0);
    check("t5_rst_gnt",   32'(bus.m_gnt_o), 32'h0);
    check("t5_rst_err",   32'(err),         32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    lat = 1;
    exp_g(base + 4, 2'b01);
    exp_r(base + 5, 2'b01, 32'hA5A5_0080, 1'b1);
    sample();
    check("t5_post_s_req", 32'(bus.s_req_o), 32'h1);
    check("t5_post_err",   32'(err),         32'h0);
    tick();
    set_m(0, 1'b0, 1'b0, 8'h00, 32'h0);
    exp_g(base + 5, 2'b10);
    exp_r(base + 6, 2'b10, 32'hA5A5_0040, 1'b1);
    tick();
    set_m(1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (3) tick();

    check("gnt_queue_drained", 32'(gq.size()), 32'h0);
    check("rsp_queue_drained", 32'(rq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
